// File: rtl/dma_client_pkg.sv
// Shared types and helpers for the DMA client descriptor muxes.
package dma_client_pkg;

  // Port-index width; a single requester still gets one index bit.
  function automatic int cl_ports(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  localparam int DESC_RAM_ADDR_W = 20;
  localparam int DESC_LEN_W      = 20;
  localparam int DESC_TAG_W      = 8;
  localparam int DESC_ID_W       = 8;
  localparam int DESC_DEST_W     = 8;
  localparam int DESC_USER_W     = 1;

  typedef struct packed {
    logic [DESC_RAM_ADDR_W-1:0] ram_addr;
    logic [DESC_LEN_W-1:0]      len;
    logic [DESC_TAG_W-1:0]      tag;
    logic [DESC_ID_W-1:0]       id;
    logic [DESC_DEST_W-1:0]     dest;
    logic [DESC_USER_W-1:0]     user;
  } desc_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the
// pointer moves past the winner when advance_i is strobed.
module rr_arbiter #(
  parameter int PORTS    = 4,
  parameter int CL_PORTS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PORTS-1:0]    req_i,
  input  logic                advance_i,
  output logic [PORTS-1:0]    grant_o,
  output logic [CL_PORTS-1:0] grant_idx_o,
  output logic                grant_valid_o,
  output logic [CL_PORTS-1:0] ptr_o
);

  logic [CL_PORTS-1:0] ptr_q;
  logic [CL_PORTS-1:0] ptr_d;
  int                  idx;

  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    idx           = 0;
    for (int off = 0; off < PORTS; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_o[idx]  = 1'b1;
        grant_idx_o   = CL_PORTS'(idx);
      end
    end
  end

  always_comb begin
    if (grant_idx_o == CL_PORTS'(PORTS - 1)) ptr_d = '0;
    else                                     ptr_d = grant_idx_o + CL_PORTS'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         ptr_q <= '0;
    else if (advance_i && grant_valid_o) ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/dma_client_desc_arb.sv
// Round-robin descriptor mux in front of one dma_client_axis_source, with
// status routed back by the port index carried in the tag MSBs.
// Optional per-port credit limit: define DMA_CLIENT_DESC_ARB_CREDIT_EN.
module dma_client_desc_arb
  import dma_client_pkg::*;
#(
  parameter  int PORTS           = 4,
  parameter  int RAM_ADDR_WIDTH  = 20,
  parameter  int LEN_WIDTH       = 20,
  parameter  int TAG_WIDTH       = 8,
  parameter  int ID_WIDTH        = 8,
  parameter  int DEST_WIDTH      = 8,
  parameter  int USER_WIDTH      = 1,
  parameter  int MAX_OUTSTANDING = 8,
  localparam int CL_PORTS        = cl_ports(PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS*RAM_ADDR_WIDTH-1:0] s_axis_desc_ram_addr,
  input  logic [PORTS*LEN_WIDTH-1:0]    s_axis_desc_len,
  input  logic [PORTS*TAG_WIDTH-1:0]    s_axis_desc_tag,
  input  logic [PORTS*ID_WIDTH-1:0]     s_axis_desc_id,
  input  logic [PORTS*DEST_WIDTH-1:0]   s_axis_desc_dest,
  input  logic [PORTS*USER_WIDTH-1:0]   s_axis_desc_user,
  input  logic [PORTS-1:0]              s_axis_desc_valid,
  output logic [PORTS-1:0]              s_axis_desc_ready,
  output logic [RAM_ADDR_WIDTH-1:0]     m_axis_desc_ram_addr,
  output logic [LEN_WIDTH-1:0]          m_axis_desc_len,
  output logic [TAG_WIDTH+CL_PORTS-1:0] m_axis_desc_tag,
  output logic [ID_WIDTH-1:0]           m_axis_desc_id,
  output logic [DEST_WIDTH-1:0]         m_axis_desc_dest,
  output logic [USER_WIDTH-1:0]         m_axis_desc_user,
  output logic                          m_axis_desc_valid,
  input  logic                          m_axis_desc_ready,
  input  logic [TAG_WIDTH+CL_PORTS-1:0] s_axis_desc_status_tag,
  input  logic                          s_axis_desc_status_valid,
  output logic [PORTS*TAG_WIDTH-1:0]    m_axis_desc_status_tag,
  output logic [PORTS-1:0]              m_axis_desc_status_valid,
  input  logic                          enable
);

  // Handshakes are valid/ready: a beat moves on a rising edge where both are
  // high; the master holds data stable while valid && !ready.

  if (PORTS < 2) begin : g_bad_ports
    $error("dma_client_desc_arb: PORTS must be >= 2");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_max
    $error("dma_client_desc_arb: MAX_OUTSTANDING must be >= 1");
  end

  logic [PORTS-1:0]    credit_ok;
  logic [PORTS-1:0]    req;
  logic [PORTS-1:0]    grant;
  logic [CL_PORTS-1:0] grant_idx;
  logic                grant_valid;
  logic [CL_PORTS-1:0] rr_ptr;
  logic                arb_en;
  logic [PORTS-1:0]    stat_hit;
  logic [CL_PORTS-1:0] stat_port;

  logic [RAM_ADDR_WIDTH-1:0]     addr_q;
  logic [LEN_WIDTH-1:0]          len_q;
  logic [TAG_WIDTH+CL_PORTS-1:0] tag_q;
  logic [ID_WIDTH-1:0]           id_q;
  logic [DEST_WIDTH-1:0]         dest_q;
  logic [USER_WIDTH-1:0]         user_q;
  logic                          valid_q;
  logic [PORTS*TAG_WIDTH-1:0]    stat_tag_q;
  logic [PORTS-1:0]              stat_valid_q;

  assign arb_en = enable && (!valid_q || m_axis_desc_ready);
  assign req    = s_axis_desc_valid & credit_ok & {PORTS{arb_en}};

  rr_arbiter #(
    .PORTS    (PORTS),
    .CL_PORTS (CL_PORTS)
  ) u_rr_arbiter (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req),
    .advance_i     (grant_valid),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid),
    .ptr_o         (rr_ptr)
  );

  // Ready is held low while in reset so nothing is lost on the release edge.
  assign s_axis_desc_ready = grant & {PORTS{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      len_q   <= '0;
      tag_q   <= '0;
      id_q    <= '0;
      dest_q  <= '0;
      user_q  <= '0;
      valid_q <= 1'b0;
    end else if (grant_valid) begin
      addr_q  <= s_axis_desc_ram_addr[grant_idx*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
      len_q   <= s_axis_desc_len[grant_idx*LEN_WIDTH +: LEN_WIDTH];
      tag_q   <= {grant_idx, s_axis_desc_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH]};
      id_q    <= s_axis_desc_id[grant_idx*ID_WIDTH +: ID_WIDTH];
      dest_q  <= s_axis_desc_dest[grant_idx*DEST_WIDTH +: DEST_WIDTH];
      user_q  <= s_axis_desc_user[grant_idx*USER_WIDTH +: USER_WIDTH];
      valid_q <= 1'b1;
    end else if (m_axis_desc_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Index decode by equality: indices >= PORTS match nothing and are dropped.
  assign stat_port = s_axis_desc_status_tag[TAG_WIDTH +: CL_PORTS];
  always_comb begin
    stat_hit = '0;
    for (int i = 0; i < PORTS; i++) begin
      stat_hit[i] = s_axis_desc_status_valid && (stat_port == CL_PORTS'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_valid_q <= '0;
      stat_tag_q   <= '0;
    end else begin
      stat_valid_q <= stat_hit;
      for (int i = 0; i < PORTS; i++) begin
        if (stat_hit[i]) stat_tag_q[i*TAG_WIDTH +: TAG_WIDTH] <= s_axis_desc_status_tag[TAG_WIDTH-1:0];
      end
    end
  end

`ifdef DMA_CLIENT_DESC_ARB_CREDIT_EN
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  logic [CNT_W-1:0] cnt_q [PORTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PORTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        case ({grant[i], stat_hit[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          2'b01:   if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  always_comb begin
    credit_ok = '0;
    for (int i = 0; i < PORTS; i++) credit_ok[i] = (cnt_q[i] != CNT_W'(MAX_OUTSTANDING));
  end
`else
  assign credit_ok = '1;
`endif

  assign m_axis_desc_ram_addr     = addr_q;
  assign m_axis_desc_len          = len_q;
  assign m_axis_desc_tag          = tag_q;
  assign m_axis_desc_id           = id_q;
  assign m_axis_desc_dest         = dest_q;
  assign m_axis_desc_user         = user_q;
  assign m_axis_desc_valid        = valid_q;
  assign m_axis_desc_status_tag   = stat_tag_q;
  assign m_axis_desc_status_valid = stat_valid_q;

endmodule
